// File: rtl/clock_gen_pkg.sv
// Shared constants and helpers for the clock divider.
// The ratio helpers operate on the widest legal ratio field.
// Callers cast their DIV_W-wide values in and out.
package clock_gen_pkg;

  localparam int DIV_MIN   = 2;
  localparam int DIV_MAX_W = 16;

  // Ratios below DIV_MIN cannot form a high and a low phase, so they are raised to DIV_MIN.
  function automatic logic [DIV_MAX_W-1:0] clamp_div(input logic [DIV_MAX_W-1:0] r);
    return (r < DIV_MAX_W'(DIV_MIN)) ? DIV_MAX_W'(DIV_MIN) : r;
  endfunction

  // Number of high cycles per period; at least 1 for any clamped ratio.
  function automatic logic [DIV_MAX_W-1:0] half_point(input logic [DIV_MAX_W-1:0] r);
    return r >> 1;
  endfunction

endpackage

// File: rtl/clock_gen_if.sv
// Control and output bundle of the clock divider.
// The master side drives enables, resync and ratios.
// The slave side (the divider) returns the divided clocks and phase pulses.
// There is no handshake. Every signal is a level that is sampled or updated on each rising clock edge.
interface clock_gen_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 4
);

  logic [CHANNELS-1:0]       EN;
  logic                      RESYNC;
  logic [CHANNELS*DIV_W-1:0] DIV;
  logic [CHANNELS-1:0]       CLK_OUT;
  logic [CHANNELS-1:0]       CLK_OUTB;
  logic [CHANNELS-1:0]       CEN_P;
  logic [CHANNELS-1:0]       CEN_N;

  modport master (
    output EN, RESYNC, DIV,
    input  CLK_OUT, CLK_OUTB, CEN_P, CEN_N
  );

  modport slave (
    input  EN, RESYNC, DIV,
    output CLK_OUT, CLK_OUTB, CEN_P, CEN_N
  );

endinterface

// File: rtl/clock_gen_chan.sv
// One divider channel.
// cnt runs 0..r-1 and the output is high while cnt < r/2.
// A new ratio is picked up only when cnt wraps, so the period in progress always completes.
// Outputs are registered from the post-edge cnt and r.
module clock_gen_chan
  import clock_gen_pkg::*;
#(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             resync,
  input  logic [DIV_W-1:0] div,
  output logic             clk_out,
  output logic             cen_p,
  output logic             cen_n
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] r;
  logic [DIV_W-1:0] cnt_next;
  logic [DIV_W-1:0] r_next;
  logic [DIV_W-1:0] h_next;
  logic [DIV_W-1:0] r_load;
  logic             out_next;
  logic             p_next;
  logic             n_next;

  assign r_load = DIV_W'(clamp_div(DIV_MAX_W'(div)));

  // Next counter, ratio and output levels: resync first, then normal counting, otherwise hold.
  always_comb begin
    cnt_next = cnt;
    r_next   = r;
    h_next   = '0;
    out_next = clk_out;
    p_next   = 1'b0;
    n_next   = 1'b0;
    if (resync) begin
      r_next = r_load;
      if (en) begin
        cnt_next = '0;
        out_next = 1'b1;
        p_next   = 1'b1;
      end else begin
        // Park one step before wrap so the first enabled edge lands on phase 0.
        cnt_next = r_load - DIV_W'(1);
        out_next = 1'b0;
      end
    end else if (en) begin
      if (cnt == r - DIV_W'(1)) begin
        cnt_next = '0;
        r_next   = r_load;
      end else begin
        cnt_next = cnt + DIV_W'(1);
      end
      h_next   = DIV_W'(half_point(DIV_MAX_W'(r_next)));
      out_next = (cnt_next < h_next);
      p_next   = (cnt_next == '0);
      n_next   = (cnt_next == h_next);
    end
  end

  // State and registered outputs. Reset parks at cnt=1 with r=2, so the first enabled edge wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= DIV_W'(1);
      r       <= DIV_W'(DIV_MIN);
      clk_out <= 1'b0;
      cen_p   <= 1'b0;
      cen_n   <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      r       <= r_next;
      clk_out <= out_next;
      cen_p   <= p_next;
      cen_n   <= n_next;
    end
  end

endmodule

// File: rtl/clock_gen.sv
// Multi-channel clock divider.
// Every channel is an independent divider clocked from CLK_24M; the only shared control is RESYNC.
// CLK_OUTB is the combinational complement of the registered clock levels.
module clock_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 4
) (
  input  logic       CLK_24M,
  input  logic       nRESETP,
  clock_gen_if.slave bus
);

  // One divider per channel, each taking its own ratio slice.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clock_gen_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk     (CLK_24M),
      .rst_n   (nRESETP),
      .en      (bus.EN[i]),
      .resync  (bus.RESYNC),
      .div     (bus.DIV[i*DIV_W +: DIV_W]),
      .clk_out (bus.CLK_OUT[i]),
      .cen_p   (bus.CEN_P[i]),
      .cen_n   (bus.CEN_N[i])
    );
  end

  assign bus.CLK_OUTB = ~bus.CLK_OUT;

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen with 4 channels and 4-bit ratios.
// Each step drives inputs on a falling edge and, after the next rising edge, queues the hand-computed outputs.
// Each queued word is {CLK_OUTB, CLK_OUT, CEN_P, CEN_N}.
// A monitor pops one word on every falling edge and compares it.
module tb_clock_gen;

  localparam int CHANNELS = 4;
  localparam int DIV_W    = 4;
  localparam int W        = 16;

  logic clk_24m;
  logic nresetp;

  logic [W-1:0] exp_q[$];
  int           tag_q[$];
  int           checks;
  int           failures;
  int           step_no;

  clock_gen_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W)) bus ();

  clock_gen #(
    .CHANNELS (CHANNELS),
    .DIV_W    (DIV_W)
  ) dut (
    .CLK_24M (clk_24m),
    .nRESETP (nresetp),
    .bus     (bus)
  );

  // Clock and reset.
  initial begin
    clk_24m = 1'b0;
    forever #5 clk_24m = ~clk_24m;
  end

  initial begin
    nresetp = 1'b0;
  end

  // Queue one expected output word.
  task automatic push_exp(input logic [3:0] eo, input logic [3:0] ep, input logic [3:0] en_n);
    exp_q.push_back({~eo, eo, ep, en_n});
    tag_q.push_back(step_no);
    step_no++;
  endtask

  // One clock step: drive on the falling edge, then queue the outputs expected after the rising edge.
  task automatic cyc(input logic rst, input logic [3:0] en, input logic rs,
                     input logic [15:0] dv, input logic [3:0] eo,
                     input logic [3:0] ep, input logic [3:0] en_n);
    @(negedge clk_24m);
    nresetp    = rst;
    bus.EN     = en;
    bus.RESYNC = rs;
    bus.DIV    = dv;
    @(posedge clk_24m);
    #1;
    push_exp(eo, ep, en_n);
  endtask

  // Monitor and scoreboard.
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp_v;
    int           tag;
    forever begin
      @(negedge clk_24m);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act   = {bus.CLK_OUTB, bus.CLK_OUT, bus.CEN_P, bus.CEN_N};
        checks++;
        if (act !== exp_v) begin
          failures++;
          $display("FAIL step%0d outb/out/p/n actual=%h required=%h", tag, act, exp_v);
        end
      end
    end
  end

  // Directed stimulus.
  // Ratios per channel are ch3..ch0 from the top nibble down.
  initial begin
    checks     = 0;
    failures   = 0;
    step_no    = 0;
    bus.EN     = '0;
    bus.RESYNC = 1'b0;
    bus.DIV    = 16'h0432;

    // Reset held: all levels low, CLK_OUTB all ones.
    cyc(1'b0, 4'hF, 1'b0, 16'h0432, 4'h0, 4'h0, 4'h0);
    cyc(1'b0, 4'hF, 1'b0, 16'h0432, 4'h0, 4'h0, 4'h0);

    // Release reset. Ratios are 2,3,4,0 (ch0..ch3); ch3 acts as ratio 2.
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'hF, 4'hF, 4'h0); // k0
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'h4, 4'h0, 4'hB); // k1
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'h9, 4'h9, 4'h4); // k2
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'h2, 4'h2, 4'h9); // k3
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'hD, 4'hD, 4'h2); // k4
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'h4, 4'h0, 4'h9); // k5
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'hB, 4'hB, 4'h4); // k6
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'h0, 4'h0, 4'hB); // k7
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'hD, 4'hD, 4'h0); // k8
    cyc(1'b1, 4'hF, 1'b0, 16'h0432, 4'h6, 4'h2, 4'h9); // k9: ch2 now at cnt=1

    // ch2 ratio 4->6 while at cnt=1: old period finishes, then 1,1,1,0,0,0.
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'h9, 4'h9, 4'h6); // k10
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'h0, 4'h0, 4'h9); // k11
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'hF, 4'hF, 4'h0); // k12: ch2 wraps to ratio 6
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'h4, 4'h0, 4'hB); // k13
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'hD, 4'h9, 4'h0); // k14
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'h2, 4'h2, 4'hD); // k15
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'h9, 4'h9, 4'h2); // k16
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'h0, 4'h0, 4'h9); // k17
    cyc(1'b1, 4'hF, 1'b0, 16'h0632, 4'hF, 4'hF, 4'h0); // k18

    // New ratios 2,3,4,5 are presented; they are not taken before each channel's wrap.
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'h4, 4'h0, 4'hB); // k19

    // Resync held for three cycles: all high with CEN_P each cycle.
    cyc(1'b1, 4'hF, 1'b1, 16'h5432, 4'hF, 4'hF, 4'h0); // k20
    cyc(1'b1, 4'hF, 1'b1, 16'h5432, 4'hF, 4'hF, 4'h0); // k21
    cyc(1'b1, 4'hF, 1'b1, 16'h5432, 4'hF, 4'hF, 4'h0); // k22
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'hC, 4'h0, 4'h3); // k23
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'h1, 4'h1, 4'hC); // k24: ch1 in low phase, cnt=2

    // ch1 disabled for five cycles: it stays low with no pulses, while the other channels run.
    cyc(1'b1, 4'hD, 1'b0, 16'h5432, 4'h0, 4'h0, 4'h1); // k25
    cyc(1'b1, 4'hD, 1'b0, 16'h5432, 4'h5, 4'h5, 4'h0); // k26
    cyc(1'b1, 4'hD, 1'b0, 16'h5432, 4'hC, 4'h8, 4'h1); // k27
    cyc(1'b1, 4'hD, 1'b0, 16'h5432, 4'h9, 4'h1, 4'h4); // k28
    cyc(1'b1, 4'hD, 1'b0, 16'h5432, 4'h0, 4'h0, 4'h9); // k29
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'h7, 4'h7, 4'h0); // k30: ch1 resumes from cnt=2 and wraps
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'h4, 4'h0, 4'h3); // k31

    // Reset pulsed mid-period. The clear is checked on the falling edge, before any further rising edge.
    @(negedge clk_24m);
    @(posedge clk_24m);
    #2;
    nresetp = 1'b0;
    #1;
    push_exp(4'h0, 4'h0, 4'h0);
    cyc(1'b0, 4'hF, 1'b0, 16'h5432, 4'h0, 4'h0, 4'h0);
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'hF, 4'hF, 4'h0);
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'hC, 4'h0, 4'h3);

    // Resync with ch1 disabled: ch1 is held low, then wraps on its first enabled edge.
    cyc(1'b1, 4'hD, 1'b1, 16'h5432, 4'hD, 4'hD, 4'h0);
    cyc(1'b1, 4'hF, 1'b0, 16'h5432, 4'hE, 4'h2, 4'h1);

    @(negedge clk_24m);
    @(negedge clk_24m);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
